// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK receive path.
// Holds the packet geometry, the preamble pattern, the byte/index types
// and the desorter FSM state encoding.
package bpsk_pkg;

  localparam int unsigned PACKET_WIDTH    = 4;
  localparam int unsigned INDEX_WIDTH     = $clog2(PACKET_WIDTH);
  localparam int unsigned PREAMBLE_LENGTH = 8;
  // Seven ones then a zero: only a zero preceded by seven ones can lock.
  localparam logic [PREAMBLE_LENGTH-1:0] PREAMBLE = 8'h7F;

  // Payload bits following the preamble: data bytes then index fields.
  localparam int unsigned PAYLOAD_BITS = PACKET_WIDTH * (8 + INDEX_WIDTH);

  typedef logic [7:0]             byte_t;
  typedef logic [INDEX_WIDTH-1:0] idx_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    SCATTER = 2'd2,
    DONE    = 2'd3
  } rx_state_t;

endpackage

// File: rtl/preamble_detector.sv
// Sliding preamble window for the desorter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bit_in      demodulated bit
//   bit_valid   bit_in is valid this cycle
//   en          window shifts and match is allowed only while high
//   clear       synchronously zeroes the window
//   match_c     combinational 1-cycle pulse: updated window equals PREAMBLE
module preamble_detector
  import bpsk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic en,
  input  logic clear,
  output logic match_c
);

  logic [PREAMBLE_LENGTH-1:0] window;
  logic [PREAMBLE_LENGTH-1:0] window_nxt_c;

  // New bit enters the MSB, so the first preamble bit ends up in the LSB.
  assign window_nxt_c = {bit_in, window[PREAMBLE_LENGTH-1:1]};
  assign match_c      = en && bit_valid && (window_nxt_c == PREAMBLE);

  // Window register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
    end else if (clear) begin
      window <= '0;
    end else if (en && bit_valid) begin
      window <= window_nxt_c;
    end
  end

endmodule

// File: rtl/desorter.sv
// Receive-side desorter: finds the preamble, collects the sorted data bytes
// and their index fields, scatters each byte back to its original slot and
// presents the restored packet.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   bit_in        demodulated bit
//   bit_valid     bit_in is valid this cycle
//   sys_packet    restored packet, held until the next packet_valid
//   packet_valid  1-cycle pulse when sys_packet updates
//   busy          high while in PAYLOAD or SCATTER
//   index_error   1-cycle pulse with packet_valid on duplicate/out-of-range index
// Option: define RX_INDEX_CHECK_EN to enable index checking; otherwise
// index_error stays 0 and duplicate indices resolve as last write wins.
module desorter
  import bpsk_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [PACKET_WIDTH-1:0][7:0]  sys_packet,
  output logic                          packet_valid,
  output logic                          busy,
  output logic                          index_error
);

  localparam int unsigned CNT_W = $clog2(PAYLOAD_BITS + 1);

  rx_state_t                   state, state_nxt;
  logic [CNT_W-1:0]            bit_cnt;
  logic [PAYLOAD_BITS-1:0]     pay;
  logic [PACKET_WIDTH-1:0][7:0] work;
  idx_t                        scat_cnt;

  logic  hunt_c, done_c, match_c, last_bit_c, last_scat_c, idx_ok_c;
  byte_t cur_data_c;
  idx_t  cur_idx_c;

`ifdef RX_INDEX_CHECK_EN
  logic [PACKET_WIDTH-1:0] seen;
  logic                    err_flag;
`endif

  assign hunt_c = (state == HUNT);
  assign done_c = (state == DONE);

  preamble_detector u_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .en        (hunt_c),
    .clear     (done_c),
    .match_c   (match_c)
  );

  // Payload register holds {indices, data} with data byte 0 in the LSBs.
  assign last_bit_c  = (state == PAYLOAD) && bit_valid &&
                       (bit_cnt == CNT_W'(PAYLOAD_BITS - 1));
  assign last_scat_c = (scat_cnt == INDEX_WIDTH'(PACKET_WIDTH - 1));
  assign cur_data_c  = pay[32'(scat_cnt) * 8 +: 8];
  assign cur_idx_c   = pay[8 * PACKET_WIDTH + 32'(scat_cnt) * INDEX_WIDTH +: INDEX_WIDTH];
  assign idx_ok_c    = (32'(cur_idx_c) < PACKET_WIDTH);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (match_c)     state_nxt = PAYLOAD;
      PAYLOAD: if (last_bit_c)  state_nxt = SCATTER;
      SCATTER: if (last_scat_c) state_nxt = DONE;
      DONE:                     state_nxt = HUNT;
      default:                  state_nxt = HUNT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      pay          <= '0;
      work         <= '0;
      scat_cnt     <= '0;
      sys_packet   <= '0;
      packet_valid <= 1'b0;
      busy         <= 1'b0;
      index_error  <= 1'b0;
`ifdef RX_INDEX_CHECK_EN
      seen         <= '0;
      err_flag     <= 1'b0;
`endif
    end else begin
      packet_valid <= 1'b0;
      index_error  <= 1'b0;
      busy         <= (state_nxt == PAYLOAD) || (state_nxt == SCATTER);
      case (state)
        HUNT: begin
          if (match_c) bit_cnt <= '0;
        end
        PAYLOAD: begin
          if (bit_valid) begin
            pay     <= {bit_in, pay[PAYLOAD_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (last_bit_c) begin
            work     <= '0;
            scat_cnt <= '0;
`ifdef RX_INDEX_CHECK_EN
            seen     <= '0;
            err_flag <= 1'b0;
`endif
          end
        end
        SCATTER: begin
          if (idx_ok_c) work[cur_idx_c] <= cur_data_c;
          scat_cnt <= scat_cnt + 1'b1;
`ifdef RX_INDEX_CHECK_EN
          if (!idx_ok_c || seen[cur_idx_c]) err_flag <= 1'b1;
          if (idx_ok_c) seen[cur_idx_c] <= 1'b1;
`endif
        end
        DONE: begin
          sys_packet   <= work;
          packet_valid <= 1'b1;
`ifdef RX_INDEX_CHECK_EN
          index_error  <= err_flag;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_desorter.sv
// Self-checking bench for desorter: directed frames with a scoreboard of
// expected packets consumed whenever packet_valid pulses.
module tb_desorter;
  import bpsk_pkg::*;

  localparam int unsigned FRAME_BITS = PREAMBLE_LENGTH + PAYLOAD_BITS;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          bit_in;
  logic                          bit_valid;
  logic [PACKET_WIDTH-1:0][7:0]  sys_packet;
  logic                          packet_valid;
  logic                          busy;
  logic                          index_error;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int pulses = 0;

  logic [PACKET_WIDTH-1:0][7:0] exp_pkt_q[$];
  logic                         exp_err_q[$];

  desorter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .sys_packet   (sys_packet),
    .packet_valid (packet_valid),
    .busy         (busy),
    .index_error  (index_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference scatter: last write wins, duplicates flagged.
  task automatic expect_pkt(input logic [PACKET_WIDTH-1:0][7:0] d,
                            input logic [PACKET_WIDTH-1:0][INDEX_WIDTH-1:0] ix);
    logic [PACKET_WIDTH-1:0][7:0] o;
    logic [PACKET_WIDTH-1:0]      seen;
    logic                         err;
    o = '0; seen = '0; err = 1'b0;
    for (int i = 0; i < int'(PACKET_WIDTH); i++) begin
      if (seen[ix[i]]) err = 1'b1;
      seen[ix[i]] = 1'b1;
      o[ix[i]] = d[i];
    end
`ifndef RX_INDEX_CHECK_EN
    err = 1'b0;
`endif
    exp_pkt_q.push_back(o);
    exp_err_q.push_back(err);
  endtask

  // Scoreboard: every packet_valid pops one expectation.
  always @(negedge clk) begin
    if (rst_n && packet_valid) begin
      pulses++;
      chk("sb_nonempty", 64'(exp_pkt_q.size() > 0), 64'd1);
      if (exp_pkt_q.size() > 0) begin
        chk("sb_packet", 64'(sys_packet), 64'(exp_pkt_q.pop_front()));
        chk("sb_index_error", 64'(index_error), 64'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b, input logic v);
    bit_in = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame; toggle inserts random invalid cycles.
  task automatic send_frame(input logic [PACKET_WIDTH-1:0][7:0] d,
                            input logic [PACKET_WIDTH-1:0][INDEX_WIDTH-1:0] ix,
                            input bit toggle, input int nbits);
    logic [FRAME_BITS-1:0] f;
    f = {ix, d, PREAMBLE};
    for (int i = 0; i < nbits; i++) begin
      if (toggle)
        while ($urandom_range(1) == 1) send_bit(1'($urandom_range(1)), 1'b0);
      send_bit(f[i], 1'b1);
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  // Cycles from the last payload edge until packet_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (packet_valid) break;
    end
  endtask

  logic [PACKET_WIDTH-1:0][7:0]             d;
  logic [PACKET_WIDTH-1:0][INDEX_WIDTH-1:0] ix;
  int lat;
  int pulses_before;

  initial begin
    rst_n = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("reset_packet_valid", 64'(packet_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_index_error", 64'(index_error), 64'd0);
    chk("reset_sys_packet", 64'(sys_packet), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame: sorted 10,20,30,40 with idx 1,3,0,2.
    d  = {8'd40, 8'd30, 8'd20, 8'd10};
    ix = {2'd2, 2'd0, 2'd3, 2'd1};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("latency_basic", 64'(lat), 64'd5);
    chk("basic_packet", 64'(sys_packet), 64'({8'd20, 8'd40, 8'd10, 8'd30}));
    chk("busy_after_done", 64'(busy), 64'd0);

    // Three noise bits, then the frame.
    repeat (3) send_bit(1'($urandom_range(1)), 1'b1);
    d  = {8'd200, 8'd128, 8'd77, 8'd5};
    ix = {2'd1, 2'd3, 2'd2, 2'd0};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("latency_noise", 64'(lat), 64'd5);

    // bit_valid toggling throughout.
    d  = {8'hF3, 8'h9C, 8'h41, 8'h07};
    ix = {2'd0, 2'd2, 2'd1, 2'd3};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b1, FRAME_BITS);
    wait_valid(lat);
    chk("latency_toggle", 64'(lat), 64'd5);

    // Reset in the middle of the payload aborts the frame.
    d  = {8'h11, 8'h22, 8'h33, 8'h44};
    ix = {2'd3, 2'd2, 2'd1, 2'd0};
    send_frame(d, ix, 1'b0, PREAMBLE_LENGTH + 20);
    chk("busy_in_payload", 64'(busy), 64'd1);
    pulses_before = pulses;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sys_packet", 64'(sys_packet), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_pulse", 64'(pulses), 64'(pulses_before));

    d  = {8'd8, 8'd6, 8'd4, 8'd2};
    ix = {2'd3, 2'd1, 2'd0, 2'd2};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("latency_after_abort", 64'(lat), 64'd5);

    // Duplicate index 1: last write wins, slot 3 never written.
    d  = {8'd40, 8'd30, 8'd20, 8'd10};
    ix = {2'd2, 2'd0, 2'd1, 2'd1};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("dup_slot1", 64'(sys_packet[1]), 64'd20);
    chk("dup_slot3", 64'(sys_packet[3]), 64'd0);
`ifdef RX_INDEX_CHECK_EN
    chk("dup_index_error", 64'(index_error), 64'd1);
`else
    chk("dup_index_error", 64'(index_error), 64'd0);
`endif

    // Back-to-back frames with no gap after DONE.
    d  = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ix = {2'd1, 2'd2, 2'd3, 2'd0};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("latency_b2b_1", 64'(lat), 64'd5);
    d  = {8'h01, 8'h02, 8'h03, 8'h04};
    ix = {2'd0, 2'd3, 2'd1, 2'd2};
    expect_pkt(d, ix);
    send_frame(d, ix, 1'b0, FRAME_BITS);
    wait_valid(lat);
    chk("latency_b2b_2", 64'(lat), 64'd5);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_pkt_q.size()), 64'd0);
    chk("pulse_count", 64'(pulses), 64'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
